// File: rtl/ifetch_queue.sv
// ifetch_queue: consumer end of the PC register interface.
//
// Issues one-outstanding instruction-memory reads at the current PC, buffers the returned
// instructions in a DEPTH-entry FIFO for decode, and tells the PC register to hold until its
// fetch is accepted. A flush empties the FIFO and discards any response still in flight.
//
// Optional feature macro: FETCH_PERF_EN adds perf_stall_o / perf_drop_o counters.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pc_i, flush_i       current PC and redirect strobe from the PC register side
//   pc_stop_o           1 = PC register must hold its value
//   imem_req_o/addr_o   read request and its address (pc_i)
//   imem_gnt_i          request accepted this cycle
//   imem_rvalid_i/rdata read response
//   id_valid_o/ready_i  decode handshake on the FIFO head
//   id_pc_o/pc4_o/instr head PC, head PC + 4, head instruction (zero while empty)
//   perf_stall_o        (FETCH_PERF_EN) cycles with pc_stop_o=1 outside boot, saturating
//   perf_drop_o         (FETCH_PERF_EN) responses discarded, saturating
module ifetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_i,
  input  logic          flush_i,
  output logic          pc_stop_o,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic          id_valid_o,
  input  logic          id_ready_i,
  output logic [AW-1:0] id_pc_o,
  output logic [AW-1:0] id_pc4_o,
  output logic [DW-1:0] id_instr_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_stall_o,
  output logic [15:0]   perf_drop_o
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StBoot, StReq, StWait, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pend_pc_q;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] reserved;
  logic [AW-1:0]   fifo_pc_q    [DEPTH];
  logic [DW-1:0]   fifo_instr_q [DEPTH];

  logic req_acc;
  logic push;
  logic pop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        // The request is masked during a flush, so a grant in the flush cycle never starts a
        // transaction; an accepted request can therefore never target a stale PC.
        if (req_acc) state_d = StWait;
      end
      StWait: begin
        // A response arriving with the flush is consumed (and dropped) right away; otherwise
        // the response still owed by memory must be swallowed later.
        if (imem_rvalid_i)  state_d = StReq;
        else if (flush_i)   state_d = StDiscard;
      end
      StDiscard: begin
        if (imem_rvalid_i) state_d = StReq;
      end
      default: state_d = StBoot;
    endcase
  end

  // Outputs and datapath strobes
  always_comb begin
    // Slot reservation: an outstanding read already owns one FIFO entry.
    reserved    = count_q + ((state_q == StWait) ? CntW'(1) : CntW'(0));
    imem_req_o  = (state_q == StReq) && (reserved < CntW'(DEPTH)) && !flush_i;
    imem_addr_o = pc_i;
    req_acc     = imem_req_o && imem_gnt_i;
    pc_stop_o   = !req_acc;

    id_valid_o  = (count_q != '0);
    if (id_valid_o) begin
      id_pc_o    = fifo_pc_q[rd_ptr_q];
      id_pc4_o   = fifo_pc_q[rd_ptr_q] + AW'(4);
      id_instr_o = fifo_instr_q[rd_ptr_q];
    end else begin
      id_pc_o    = '0;
      id_pc4_o   = '0;
      id_instr_o = '0;
    end

    push = (state_q == StWait) && imem_rvalid_i && !flush_i;
    pop  = id_valid_o && id_ready_i && !flush_i;
  end

  // FIFO pointer / occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pend_pc_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (req_acc) pend_pc_q <= pc_i;
    end
  end

  // Storage needs no reset: head outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= pend_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

`ifdef FETCH_PERF_EN
  logic        drop_evt;
  logic [31:0] stall_q;
  logic [15:0] drop_q;

  assign drop_evt = imem_rvalid_i &&
                    ((state_q == StDiscard) || ((state_q == StWait) && flush_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      if (pc_stop_o && (state_q != StBoot) && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (drop_evt && (drop_q != '1))                          drop_q  <= drop_q + 16'd1;
    end
  end

  assign perf_stall_o = stall_q;
  assign perf_drop_o  = drop_q;
`endif

endmodule
